// File: rtl/alsu_cmd_master.sv
// Single-outstanding command initiator for the ALSU: drives registered pins, waits out
// ALSU latency, captures out/leds. Optional prediction checker: ALSU_MASTER_CHECK_EN.
module alsu_cmd_master #(
    parameter int ALSU_LATENCY   = 2,
    parameter     INPUT_PRIORITY = "A"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_a,
    input  logic [2:0]  req_b,
    input  logic [2:0]  req_opcode,
    input  logic [6:0]  req_ctrl,
    output logic [2:0]  alsu_a,
    output logic [2:0]  alsu_b,
    output logic [2:0]  alsu_opcode,
    output logic [6:0]  alsu_ctrl,
    input  logic [5:0]  alsu_out,
    input  logic [15:0] alsu_leds,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [5:0]  rsp_out,
    output logic [15:0] rsp_leds,
    output logic        rsp_invalid,
    output logic        rsp_mismatch
);

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, RESP} state_t;

    localparam logic [2:0] CNT_LOAD = 3'(ALSU_LATENCY - 1);

    generate
        if (ALSU_LATENCY < 2 || ALSU_LATENCY > 7) begin : g_bad_latency
            $error("alsu_cmd_master: ALSU_LATENCY must be 2..7");
        end
        if (INPUT_PRIORITY != "A" && INPUT_PRIORITY != "B") begin : g_bad_prio
            $error("alsu_cmd_master: INPUT_PRIORITY must be A or B");
        end
    endgenerate

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic        accept;
    logic        capture;
    logic        invalid_next;

    logic [2:0]  a_reg, b_reg, opcode_reg;
    logic [6:0]  ctrl_reg;
    logic [5:0]  out_reg;
    logic [15:0] leds_reg;
    logic        invalid_reg;

    assign accept  = (state_reg == IDLE) && req_valid;
    assign capture = (state_reg == SAMPLE);

    // Reduction ops are only legal with OR/XOR; opcodes 6 and 7 are always illegal.
    assign invalid_next = ((req_ctrl[4] | req_ctrl[3]) & (req_opcode[1] | req_opcode[2]))
                        | (req_opcode[1] & req_opcode[2]);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = WAIT;
                    cnt_next   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_reg == 3'd0) begin
                    state_next = SAMPLE;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            SAMPLE: state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Pins hold the last accepted command until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg       <= 3'd0;
            b_reg       <= 3'd0;
            opcode_reg  <= 3'd0;
            ctrl_reg    <= 7'd0;
            invalid_reg <= 1'b0;
        end else if (accept) begin
            a_reg       <= req_a;
            b_reg       <= req_b;
            opcode_reg  <= req_opcode;
            ctrl_reg    <= req_ctrl;
            invalid_reg <= invalid_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg  <= 6'd0;
            leds_reg <= 16'd0;
        end else if (capture) begin
            out_reg  <= alsu_out;
            leds_reg <= alsu_leds;
        end
    end

    assign req_ready   = (state_reg == IDLE);
    assign rsp_valid   = (state_reg == RESP);
    assign alsu_a      = a_reg;
    assign alsu_b      = b_reg;
    assign alsu_opcode = opcode_reg;
    assign alsu_ctrl   = ctrl_reg;
    assign rsp_out     = out_reg;
    assign rsp_leds    = leds_reg;
    assign rsp_invalid = invalid_reg;

`ifdef ALSU_MASTER_CHECK_EN
    localparam bit PRIO_A = (INPUT_PRIORITY == "A");

    logic [5:0] pred_out;
    logic       pred_en;
    logic       mismatch_reg;

    function automatic logic [5:0] predict(
        input logic [2:0] a,
        input logic [2:0] b,
        input logic [2:0] op,
        input logic       red_a,
        input logic       red_b,
        input logic       byp_a,
        input logic       byp_b,
        input logic       inv
    );
        logic signed [5:0] sa;
        logic signed [5:0] sb;
        logic [5:0]        r;
        sa = {{3{a[2]}}, a};
        sb = {{3{b[2]}}, b};
        r  = 6'd0;
        if (byp_a && byp_b) begin
            r = PRIO_A ? sa : sb;
        end else if (byp_a) begin
            r = sa;
        end else if (byp_b) begin
            r = sb;
        end else if (inv) begin
            r = 6'd0;
        end else begin
            case (op)
                3'd0: begin
                    if (red_a && red_b) r = PRIO_A ? {5'd0, |a} : {5'd0, |b};
                    else if (red_a)     r = {5'd0, |a};
                    else if (red_b)     r = {5'd0, |b};
                    else                r = {3'd0, a | b};
                end
                3'd1: begin
                    if (red_a && red_b) r = PRIO_A ? {5'd0, ^a} : {5'd0, ^b};
                    else if (red_a)     r = {5'd0, ^a};
                    else if (red_b)     r = {5'd0, ^b};
                    else                r = {3'd0, a ^ b};
                end
                3'd2:    r = sa + sb;
                3'd3:    r = sa * sb;
                default: r = 6'd0;
            endcase
        end
        return r;
    endfunction

    assign pred_out = predict(a_reg, b_reg, opcode_reg, ctrl_reg[4], ctrl_reg[3],
                              ctrl_reg[2], ctrl_reg[1], invalid_reg);
    // Shift/rotate opcodes depend on ALSU history and are left unchecked.
    assign pred_en  = (opcode_reg != 3'd4) && (opcode_reg != 3'd5);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_reg <= 1'b0;
        end else if (capture) begin
            mismatch_reg <= pred_en && (pred_out != alsu_out);
        end
    end

    assign rsp_mismatch = mismatch_reg;
`else
    assign rsp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alsu_cmd_master.sv
// Directed bench for alsu_cmd_master; the bench itself plays the ALSU by driving
// alsu_out/alsu_leds only in the cycle the real ALSU output register would hold them.
module tb_alsu_cmd_master;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_a, req_b, req_opcode;
    logic [6:0]  req_ctrl;
    logic [2:0]  alsu_a, alsu_b, alsu_opcode;
    logic [6:0]  alsu_ctrl;
    logic [5:0]  alsu_out;
    logic [15:0] alsu_leds;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [5:0]  rsp_out;
    logic [15:0] rsp_leds;
    logic        rsp_invalid;
    logic        rsp_mismatch;

    int n_checks = 0;
    int n_fail   = 0;

    alsu_cmd_master #(
        .ALSU_LATENCY   (LAT),
        .INPUT_PRIORITY ("A")
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_opcode   (req_opcode),
        .req_ctrl     (req_ctrl),
        .alsu_a       (alsu_a),
        .alsu_b       (alsu_b),
        .alsu_opcode  (alsu_opcode),
        .alsu_ctrl    (alsu_ctrl),
        .alsu_out     (alsu_out),
        .alsu_leds    (alsu_leds),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_out      (rsp_out),
        .rsp_leds     (rsp_leds),
        .rsp_invalid  (rsp_invalid),
        .rsp_mismatch (rsp_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                        input logic [6:0] ctrl);
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_a      = a;
        req_b      = b;
        req_opcode = op;
        req_ctrl   = ctrl;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("pin_a", 32'(alsu_a), 32'(a));
        chk("pin_b", 32'(alsu_b), 32'(b));
        chk("pin_op", 32'(alsu_opcode), 32'(op));
        chk("pin_ctrl", 32'(alsu_ctrl), 32'(ctrl));
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        $display("accept a=%0d b=%0d op=%0d ctrl=%b at %0t", a, b, op, ctrl, $time);
    endtask

    // Called 1 time unit after the accept edge.
    task automatic complete(input string tag, input logic [5:0] out_val,
                            input logic [15:0] leds_val, input logic exp_inv,
                            input int hold, input logic [2:0] cur_op, input bit pend,
                            input logic [2:0] pa, input logic [2:0] pb,
                            input logic [2:0] pop, input logic [6:0] pctrl);
        alsu_out  = out_val ^ 6'h2A;
        alsu_leds = leds_val ^ 16'h1234;
        for (int i = 1; i <= LAT; i++) begin
            @(posedge clk);
            #1;
            chk("rsp_valid_early", 32'(rsp_valid), 32'd0);
            if (i == LAT) begin
                alsu_out  = out_val;
                alsu_leds = leds_val;
            end
        end
        @(posedge clk);
        #1;
        alsu_out  = out_val ^ 6'h15;
        alsu_leds = leds_val ^ 16'h5A5A;
        chk("rsp_valid_rise", 32'(rsp_valid), 32'd1);
        chk("rsp_out", 32'(rsp_out), 32'(out_val));
        chk("rsp_leds", 32'(rsp_leds), 32'(leds_val));
        chk("rsp_invalid", 32'(rsp_invalid), 32'(exp_inv));
        chk("rsp_mismatch", 32'(rsp_mismatch), 32'd0);
        chk("req_ready_resp", 32'(req_ready), 32'd0);
        if (pend) begin
            req_valid  = 1'b1;
            req_a      = pa;
            req_b      = pb;
            req_opcode = pop;
            req_ctrl   = pctrl;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_out", 32'(rsp_out), 32'(out_val));
            chk("hold_leds", 32'(rsp_leds), 32'(leds_val));
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_pin_op", 32'(alsu_opcode), 32'(cur_op));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rsp_valid_fall", 32'(rsp_valid), 32'd0);
        chk("req_ready_back", 32'(req_ready), 32'd1);
        chk("pin_op_held", 32'(alsu_opcode), 32'(cur_op));
        $display("response %s out=%b leds=%h invalid=%0d at %0t",
                 tag, rsp_out, rsp_leds, rsp_invalid, $time);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_a      = 3'd0;
        req_b      = 3'd0;
        req_opcode = 3'd0;
        req_ctrl   = 7'd0;
        alsu_out   = 6'd0;
        alsu_leds  = 16'd0;
        rsp_ready  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_out", 32'(rsp_out), 32'd0);
        chk("rst_rsp_leds", 32'(rsp_leds), 32'd0);
        chk("rst_rsp_invalid", 32'(rsp_invalid), 32'd0);
        chk("rst_rsp_mismatch", 32'(rsp_mismatch), 32'd0);
        chk("rst_pins", 32'({alsu_a, alsu_b, alsu_opcode, alsu_ctrl}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        $display("reset released at %0t", $time);

        // 3 + (-2) = 1
        send(3'b011, 3'b110, 3'd2, 7'b0000000);
        complete("add", 6'b000001, 16'h0000, 1'b0, 0, 3'd2, 1'b0, 3'd0, 3'd0, 3'd0, 7'd0);

        // -3 * 3 = -9 -> 6'b110111
        send(3'b101, 3'b011, 3'd3, 7'b0000000);
        complete("mul", 6'b110111, 16'h0000, 1'b0, 0, 3'd3, 1'b0, 3'd0, 3'd0, 3'd0, 7'd0);

        // reduction with ADD is invalid
        send(3'b001, 3'b001, 3'd2, 7'b0010000);
        complete("inv_red", 6'b000000, 16'hFFFF, 1'b1, 0, 3'd2, 1'b0, 3'd0, 3'd0, 3'd0, 7'd0);

        // both bypasses, priority A -> 2
        send(3'b010, 3'b111, 3'd0, 7'b0000110);
        complete("bypass", 6'b000010, 16'h0000, 1'b0, 0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 7'd0);

        // backpressure 5 cycles: 011 ^ 101 = 110; an OR request arrives during RESP
        send(3'b011, 3'b101, 3'd1, 7'b0000000);
        rsp_ready = 1'b0;
        complete("xor_bp", 6'b000110, 16'h0000, 1'b0, 5, 3'd1, 1'b1,
                 3'b001, 3'b100, 3'd0, 7'b0000000);

        // the held request is taken only after the handshake: 001 | 100 = 101
        send(3'b001, 3'b100, 3'd0, 7'b0000000);
        complete("or", 6'b000101, 16'h0000, 1'b0, 0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 7'd0);

        // reset while in WAIT drops the command
        send(3'b001, 3'b001, 3'd3, 7'b1000001);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pins", 32'({alsu_a, alsu_b, alsu_opcode, alsu_ctrl}), 32'd0);
        chk("async_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_pins", 32'({alsu_a, alsu_b, alsu_opcode, alsu_ctrl}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("dropped_no_rsp", 32'(rsp_valid), 32'd0);
        end
        $display("reset pulse in WAIT handled at %0t", $time);

        // opcode 6 is invalid
        send(3'b010, 3'b001, 3'd6, 7'b0000000);
        complete("op6", 6'b000000, 16'hFFFF, 1'b1, 0, 3'd6, 1'b0, 3'd0, 3'd0, 3'd0, 7'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
